// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan multiplexer.
// Segment patterns are active-high {G,F,E,D,C,B,A}; polarity is applied at the top.
package seg_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_OFF   = 7'h00;
  localparam logic [6:0] SEG_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h6F;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;  // lowercase b
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;  // lowercase d
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex nibble to active-high seven-segment pattern {G,F,E,D,C,B,A}.
module hex7seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (nibble_i)
      4'h0: seg_o = SEG_HEX_0;
      4'h1: seg_o = SEG_HEX_1;
      4'h2: seg_o = SEG_HEX_2;
      4'h3: seg_o = SEG_HEX_3;
      4'h4: seg_o = SEG_HEX_4;
      4'h5: seg_o = SEG_HEX_5;
      4'h6: seg_o = SEG_HEX_6;
      4'h7: seg_o = SEG_HEX_7;
      4'h8: seg_o = SEG_HEX_8;
      4'h9: seg_o = SEG_HEX_9;
      4'hA: seg_o = SEG_HEX_A;
      4'hB: seg_o = SEG_HEX_B;
      4'hC: seg_o = SEG_HEX_C;
      4'hD: seg_o = SEG_HEX_D;
      4'hE: seg_o = SEG_HEX_E;
      4'hF: seg_o = SEG_HEX_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Four-digit multiplexed seven-segment driver with anti-ghost blanking and a
// frame-synchronous shadow register. Define SEG_LZB_EN for leading-zero blanking.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int SCAN_DIV       = 50_000,
  parameter int BLANK_CYC      = 500,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic        i_clk,
  input  logic        rst_n,
  input  logic [15:0] i_value,
  input  logic        i_load,
  output logic        o_pending,
  output logic [6:0]  o_seg,
  output logic [3:0]  o_dig_en_n
);

  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] T_LAST       = TW'(SCAN_DIV - 1);
  localparam logic [TW-1:0] T_BLANK_LAST = TW'(BLANK_CYC - 1);
  localparam logic [6:0]    SEG_OFF_OUT  = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;

  scan_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    index_q, index_d;
  logic [15:0]   display_q, display_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    dig_en_n_q, dig_en_n_d;

  logic          commit;
  logic          lz_blank;
  logic [3:0]    nibble_d;
  logic [6:0]    dec_seg;
  logic [6:0]    raw_seg;

  hex7seg_decode u_decode (
    .nibble_i (nibble_d),
    .seg_o    (dec_seg)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    index_d = index_q;
    commit  = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (timer_q == T_BLANK_LAST) state_d = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (timer_q == T_LAST) begin
          state_d = ST_BLANK;
          timer_d = '0;
          index_d = index_q + 2'd1;
          commit  = (index_q == 2'd3);
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  // Commit uses the shadow as it stood before this edge, so a coincident load
  // lands in the shadow and stays pending for the next frame.
  always_comb begin
    shadow_d  = i_load ? i_value : shadow_q;
    display_d = (commit && pending_q) ? shadow_q : display_q;
    pending_d = pending_q;
    if (i_load)      pending_d = 1'b1;
    else if (commit) pending_d = 1'b0;
  end

  // Outputs are computed from next-state values so they register on the
  // same edge as the state/index change.
  always_comb begin
    nibble_d = display_d[3:0];
    case (index_d)
      2'd0: nibble_d = display_d[3:0];
      2'd1: nibble_d = display_d[7:4];
      2'd2: nibble_d = display_d[11:8];
      2'd3: nibble_d = display_d[15:12];
      default: nibble_d = display_d[3:0];
    endcase
`ifdef SEG_LZB_EN
    lz_blank = 1'b0;
    case (index_d)
      2'd1: lz_blank = (display_d[15:4] == 12'h000);
      2'd2: lz_blank = (display_d[15:8] == 8'h00);
      2'd3: lz_blank = (display_d[15:12] == 4'h0);
      default: lz_blank = 1'b0;
    endcase
`else
    lz_blank = 1'b0;
`endif
    raw_seg    = (state_d == ST_DRIVE && !lz_blank) ? dec_seg : SEG_OFF;
    seg_d      = (SEG_ACTIVE_LOW != 0) ? ~raw_seg : raw_seg;
    dig_en_n_d = (state_d == ST_DRIVE) ? ~(4'b0001 << index_d) : 4'b1111;
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BLANK;
      timer_q    <= '0;
      index_q    <= 2'd0;
      display_q  <= 16'h0000;
      shadow_q   <= 16'h0000;
      pending_q  <= 1'b0;
      seg_q      <= SEG_OFF_OUT;
      dig_en_n_q <= 4'b1111;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      index_q    <= index_d;
      display_q  <= display_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      seg_q      <= seg_d;
      dig_en_n_q <= dig_en_n_d;
    end
  end

  assign o_pending  = pending_q;
  assign o_seg      = seg_q;
  assign o_dig_en_n = dig_en_n_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux at SCAN_DIV=10, BLANK_CYC=2, active-low segments.
// Expected frames come from a hand-written digit table; define SEG_LZB_EN to match a blanking build.
module tb_seg_scan_mux;

  logic        i_clk;
  logic        rst_n;
  logic [15:0] i_value;
  logic        i_load;
  logic        o_pending;
  logic [6:0]  o_seg;
  logic [3:0]  o_dig_en_n;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];

  seg_scan_mux #(
    .SCAN_DIV       (10),
    .BLANK_CYC      (2),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .i_clk      (i_clk),
    .rst_n      (rst_n),
    .i_value    (i_value),
    .i_load     (i_load),
    .o_pending  (o_pending),
    .o_seg      (o_seg),
    .o_dig_en_n (o_dig_en_n)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Active-low {G,F,E,D,C,B,A} patterns for hex digits.
  function automatic logic [6:0] hex_al(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [6:0] exp_digit(input logic [15:0] value, input int d);
    logic [3:0] nib;
    nib = 4'((value >> (4 * d)) & 16'hF);
`ifdef SEG_LZB_EN
    if (d > 0 && (value >> (4 * d)) == 16'h0) return 7'b1111111;
`endif
    return hex_al(nib);
  endfunction

  // driver tasks
  task automatic expect_frame(input logic [15:0] value);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 10; c++) begin
        if (c < 2) exp_q.push_back({4'b1111, 7'b1111111});
        else       exp_q.push_back({~(4'b0001 << d), exp_digit(value, d)});
      end
    end
  endtask

  task automatic run_cycles(input int n, input int load_at, input logic [15:0] val);
    logic [10:0] e;
    for (int c = 0; c < n; c++) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 16'd0, 16'd1);
      end else begin
        e = exp_q.pop_front();
        check("scan_out", {5'd0, o_dig_en_n, o_seg}, {5'd0, e});
      end
      if (c == load_at) begin
        i_value = val;
        i_load  = 1'b1;
      end
      step();
      i_load = 1'b0;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    i_load  = 1'b0;
    i_value = 16'h0000;
    step();
    step();
    check("rst_dig_en", {12'd0, o_dig_en_n}, 16'h000F);
    check("rst_seg", {9'd0, o_seg}, 16'h007F);
    check("rst_pending", {15'd0, o_pending}, 16'd0);
    rst_n = 1'b1;

    // idle frame after reset: display 0
    expect_frame(16'h0000);
    run_cycles(40, -1, 16'h0);
    check("idle_pending", {15'd0, o_pending}, 16'd0);

    // load mid digit-1 slot; display holds until wrap
    expect_frame(16'h0000);
    run_cycles(15, -1, 16'h0);
    run_cycles(1, 0, 16'h1A3F);
    check("load_pending", {15'd0, o_pending}, 16'd1);
    run_cycles(24, -1, 16'h0);
    check("commit_clears", {15'd0, o_pending}, 16'd0);

    // new frame shows 1A3F; two loads before commit, last wins
    expect_frame(16'h1A3F);
    run_cycles(5, -1, 16'h0);
    run_cycles(1, 0, 16'h1111);
    run_cycles(19, -1, 16'h0);
    run_cycles(1, 0, 16'h2222);
    check("overwrite_pending", {15'd0, o_pending}, 16'd1);
    run_cycles(14, -1, 16'h0);
    check("commit2_clears", {15'd0, o_pending}, 16'd0);

    // load 5555 on the exact commit edge: old shadow 3333 commits
    expect_frame(16'h2222);
    run_cycles(10, -1, 16'h0);
    run_cycles(1, 0, 16'h3333);
    run_cycles(28, -1, 16'h0);
    check("pre_edge_pending", {15'd0, o_pending}, 16'd1);
    run_cycles(1, 0, 16'h5555);
    check("edge_load_pending", {15'd0, o_pending}, 16'd1);

    expect_frame(16'h3333);
    run_cycles(40, -1, 16'h0);
    check("late_commit_clears", {15'd0, o_pending}, 16'd0);

    // asynchronous reset during digit-2 drive
    expect_frame(16'h5555);
    run_cycles(25, -1, 16'h0);
    check("pre_rst_dig_en", {12'd0, o_dig_en_n}, 16'h000B);
    rst_n = 1'b0;
    #1;
    check("async_rst_dig_en", {12'd0, o_dig_en_n}, 16'h000F);
    check("async_rst_seg", {9'd0, o_seg}, 16'h007F);
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;

    // restart at digit 0 with display cleared
    expect_frame(16'h0000);
    run_cycles(40, -1, 16'h0);

    // leading-zero candidate value
    expect_frame(16'h0000);
    run_cycles(1, 0, 16'h0040);
    run_cycles(39, -1, 16'h0);
    expect_frame(16'h0040);
    run_cycles(40, -1, 16'h0);
    check("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50_000: i_clk cycles per digit slot, BLANK plus DRIVE (1 kHz per digit at 50 MHz).
REQ-002 SHALL have parameter BLANK_CYC, default 500: anti-ghosting blank cycles at the start of each slot; legal range 1 <= BLANK_CYC < SCAN_DIV.
REQ-003 SHALL have parameter SEG_ACTIVE_LOW, default 1: 1 = segment on is 0; 0 = segment on is 1.
REQ-004 SHALL have port i_clk, input, 1 bit: clock.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port i_value, input, 16 bits: four hex nibbles; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
REQ-007 SHALL have port i_load, input, 1 bit: single-cycle strobe that captures i_value into the shadow register.
REQ-008 SHALL have port o_pending, output, 1 bit: shadow value not yet committed to the display.
REQ-009 SHALL have port o_seg, output, 7 bits: {G,F,E,D,C,B,A} segment drive, polarity per SEG_ACTIVE_LOW.
REQ-010 SHALL have port o_dig_en_n, output, 4 bits: active-low digit enables; bit n drives digit n.

Function
REQ-011 SHALL implement a two-state FSM {BLANK, DRIVE}, a slot timer 0..SCAN_DIV-1 and a 2-bit digit index.
REQ-012 BLANK SHALL last exactly BLANK_CYC cycles, with o_dig_en_n = 4'b1111 and all segments off.
REQ-013 DRIVE SHALL last exactly SCAN_DIV-BLANK_CYC cycles, with only o_dig_en_n[index] low and o_seg = decode(display nibble[index]).
REQ-014 At DRIVE end, FSM SHALL go to BLANK, index SHALL increment mod 4 (3 wraps to 0) and the timer SHALL reset to 0.
REQ-015 Frame period SHALL be exactly 4*SCAN_DIV cycles.
REQ-016 All outputs SHALL be registered and SHALL change on the same edge as the FSM/index transition, with no combinational path from inputs.
REQ-017 i_load=1 SHALL capture i_value into shadow and set o_pending on the next edge; a load while pending SHALL overwrite shadow.
REQ-018 Commit: on the edge where index wraps 3->0 (entering BLANK), if o_pending is set, display SHALL take shadow and o_pending SHALL clear. Digit values therefore never tear mid-frame.
REQ-019 Simultaneous i_load and commit: display SHALL take the old shadow, shadow SHALL take the new i_value, and o_pending SHALL remain 1.
REQ-020 Decode SHALL cover hex 0-F: standard patterns, with A,C,E,F uppercase and b,d lowercase.

Reset
REQ-021 rst_n low SHALL asynchronously force: state BLANK, timer 0, index 0, display 0, shadow 0, o_pending 0, o_dig_en_n 4'b1111, segments off.
REQ-022 Reset mid-slot SHALL abort the slot; after release the first DRIVE SHALL be digit 0, beginning BLANK_CYC cycles later.

Configuration
REQ-023 Macro SEG_LZB_EN defined: in DRIVE, digits 3..1 SHALL show segments off when that nibble and all higher nibbles are zero; the enable is still asserted; digit 0 is always shown.
REQ-024 Macro SEG_LZB_EN undefined: all four digits SHALL always be decoded.

Structure
REQ-025 Package seg_pkg SHALL hold the FSM state enum, the 7-bit segment pattern constants for 0-F and SEG_OFF.
REQ-026 Sub-module hex7seg_decode SHALL be combinational nibble-to-active-high segments; seg_scan_mux SHALL apply polarity and register the result.

Verification (SCAN_DIV=10, BLANK_CYC=2, SEG_ACTIVE_LOW=1)
REQ-027 Reset release, no load -> 2 cycles of dig_en_n=1111, then 8 cycles of 1110 with seg=7'b1000000 ("0"), then 2 blank cycles, then 8 cycles of 1101; period 40.
REQ-028 i_load with 16'h1A3F mid digit-1 slot -> o_pending=1 and display unchanged until the 3->0 wrap; next frame digit0=F (7'b0001110), digit3=1 (7'b1111001); o_pending then 0.
REQ-029 Two loads, 16'h1111 then 16'h2222, before commit -> display 16'h2222 after wrap.
REQ-030 i_load of 16'h5555 on the exact commit edge -> display takes the prior shadow, o_pending stays 1, and 16'h5555 appears one frame later.
REQ-031 rst_n pulsed during DRIVE of digit 2 -> outputs off immediately (asynchronous), display 0, restart at digit 0.
REQ-032 SEG_LZB_EN defined, value 16'h0040 -> digits 3 and 2 show seg=7'b1111111 with enables still pulsed; digit 1 shows "4"; digit 0 shows "0".
